seg7_scan_reader: RTL

Receive-side monitor for a 4-digit multiplexed, active-low seven-segment bus (segments plus anode enables), the type our display drivers emit. It samples the bus pins, waits for each digit's dwell to settle, and decodes the segment pattern back to a hex nibble. Each digit is captured once, and the block publishes a complete 4-digit word atomically per scan frame. It sits on the readback/self-check side, either looped back from a driver's pins or attached to an external display bus.

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_pattern_decode.sv | 23 ++
 rtl/seg7_scan_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern table and anode helpers shared by the display drivers
// and the scan-bus readback logic.
package seg7_pkg;

    // Idle levels of the active-low bus
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_NONE   = 4'hF;

    // Active-low gfedcba patterns for the hex glyphs 0..F
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Packed so that entry n is the pattern for glyph n
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    // How a settled anode vector should be treated
    typedef enum logic [1:0] {
        AN_CLASS_BLANK,
        AN_CLASS_ONE,
        AN_CLASS_MULTI
    } anClass_t;

    function automatic anClass_t classifyAnode(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return AN_CLASS_ONE;
            AN_NONE:                            return AN_CLASS_BLANK;
            default:                            return AN_CLASS_MULTI;
        endcase
    endfunction

    // Digit index selected by a one-low anode; other inputs map to 0
    function automatic logic [1:0] activeDigit(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low segment pattern back to its hex nibble.
// Patterns outside the glyph table decode to nibble 0 with legal cleared.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       legal_o
);

    // Table search over the 16 shared glyph patterns
    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg_i == SEG_TABLE[k]) begin
                nibble_o = 4'(k);
                legal_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: receive-side monitor for a 4-digit multiplexed active-low
// seven-segment bus. Each digit dwell is captured once after it settles, and a
// complete 4-digit word is published atomically per scan frame.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        value_stable,
    output logic        stale,
    output logic        an_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 2);

    logic [10:0]   sync1_q, sync2_q, pairPrev_q;
    logic [SW-1:0] settleCnt_q, settleCnt_d;
    logic          captured_q, captured_d;
    logic [3:0]    seenMask_q, seenMask_d;
    logic [15:0]   shadowNib_q, shadowNib_d;
    logic [3:0]    shadowLegal_q, shadowLegal_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    digitValid_q, digitValid_d;
    logic          frameValid_q, frameValid_d;
    logic          valueStable_q, valueStable_d;
    logic          stale_q, stale_d;
    logic          anErr_q, anErr_d;

    logic [3:0] settledAn;
    logic [6:0] settledSeg;
    logic [3:0] decNibble;
    logic       decLegal;
    logic       pairChanged;
    logic       settleFire;
    logic       digitCapture;
    logic       frameDone;
    logic       timeoutHit;
    anClass_t   anClass;
    logic [1:0] anIdx;

    assign settledAn  = sync2_q[10:7];
    assign settledSeg = sync2_q[6:0];
    assign anClass    = classifyAnode(settledAn);
    assign anIdx      = activeDigit(settledAn);

    seg7_pattern_decode u_decode (
        .seg_i    (settledSeg),
        .nibble_o (decNibble),
        .legal_o  (decLegal)
    );

    // Settle tracking: restart on any change, fire once when the dwell has held long enough
    always_comb begin
        pairChanged = (sync2_q != pairPrev_q);
        settleCnt_d = settleCnt_q;
        captured_d  = captured_q;
        if (pairChanged) begin
            settleCnt_d = '0;
            captured_d  = 1'b0;
        end else if (settleCnt_q != SETTLE_MAX) begin
            settleCnt_d = settleCnt_q + SW'(1);
        end
        settleFire = !pairChanged && !captured_q && (settleCnt_d == SETTLE_MAX);
        if (settleFire) begin
            captured_d = 1'b1;
        end
    end

    assign digitCapture = settleFire && (anClass == AN_CLASS_ONE);
    assign frameDone    = (seenMask_q == 4'hF);
    assign timeoutHit   = !digitCapture && (timeout_q == TIMEOUT_PRE);

    // Shadow capture, frame publication and capture-timeout handling
    always_comb begin
        seenMask_d    = seenMask_q;
        shadowNib_d   = shadowNib_q;
        shadowLegal_d = shadowLegal_q;
        timeout_d     = timeout_q;
        digits_d      = digits_q;
        digitValid_d  = digitValid_q;
        frameValid_d  = frameDone;
        valueStable_d = valueStable_q;
        stale_d       = stale_q;
        anErr_d       = settleFire && (anClass == AN_CLASS_MULTI);

        if (frameDone || timeoutHit) begin
            seenMask_d = 4'h0;
        end
        if (digitCapture) begin
            seenMask_d[anIdx]               = 1'b1;
            shadowNib_d[{anIdx, 2'b00} +: 4] = decNibble;
            shadowLegal_d[anIdx]            = decLegal;
            timeout_d                       = '0;
        end else if (timeout_q != TIMEOUT_MAX) begin
            timeout_d = timeout_q + TW'(1);
        end

        if (frameDone) begin
            digits_d      = shadowNib_q;
            digitValid_d  = shadowLegal_q;
            valueStable_d = ({shadowNib_q, shadowLegal_q} == {digits_q, digitValid_q});
            stale_d       = 1'b0;
        end else if (timeoutHit) begin
            stale_d       = 1'b1;
            valueStable_d = 1'b0;
        end
    end

    // Two-flop synchronizer on the raw bus pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {an_in, seg_in};
            sync2_q <= sync1_q;
        end
    end

    // State registers for settle, shadows, timeout and published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pairPrev_q    <= '0;
            settleCnt_q   <= '0;
            captured_q    <= 1'b0;
            seenMask_q    <= 4'h0;
            shadowNib_q   <= 16'h0;
            shadowLegal_q <= 4'h0;
            timeout_q     <= '0;
            digits_q      <= 16'h0;
            digitValid_q  <= 4'h0;
            frameValid_q  <= 1'b0;
            valueStable_q <= 1'b0;
            stale_q       <= 1'b0;
            anErr_q       <= 1'b0;
        end else begin
            pairPrev_q    <= sync2_q;
            settleCnt_q   <= settleCnt_d;
            captured_q    <= captured_d;
            seenMask_q    <= seenMask_d;
            shadowNib_q   <= shadowNib_d;
            shadowLegal_q <= shadowLegal_d;
            timeout_q     <= timeout_d;
            digits_q      <= digits_d;
            digitValid_q  <= digitValid_d;
            frameValid_q  <= frameValid_d;
            valueStable_q <= valueStable_d;
            stale_q       <= stale_d;
            anErr_q       <= anErr_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = digitValid_q;
    assign frame_valid  = frameValid_q;
    assign value_stable = valueStable_q;
    assign stale        = stale_q;
    assign an_err       = anErr_q;

endmodule
